// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU-side requester and mem_responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Big-endian byte-addressed memory responder: one request at a time, LATENCY wait cycles.
// Define SIGN_EXT_EN to sign-extend byte/half reads requested with req_signed=1.
module mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

`ifdef SIGN_EXT_EN
    localparam bit SIGN_EXT = 1'b1;
`else
    localparam bit SIGN_EXT = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0]        mem [0:(1 << ADDR_W) - 1];

    logic              accept;
    logic              go_resp;
    logic              c_we;
    logic [1:0]        c_size;
    logic              c_sgn;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic              c_err;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic              ext;
    logic [31:0]       rd_val;

    assign bus.req_ready = reset && (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign accept  = bus.req_valid && bus.req_ready;
    assign go_resp = (accept && (LATENCY == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'(LATENCY)));

    // With zero latency the access happens on the acceptance edge itself,
    // so the live inputs are used instead of the not-yet-latched copies.
    always_comb begin
        c_we    = we_q;
        c_size  = size_q;
        c_sgn   = sgn_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state == S_IDLE) begin
            c_we    = bus.req_we;
            c_size  = bus.req_size;
            c_sgn   = bus.req_signed;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
        end
    end

    always_comb begin
        c_err = 1'b0;
        if ((c_addr >> ADDR_W) != 32'd0)                  c_err = 1'b1;
        if (c_size == 2'b11)                              c_err = 1'b1;
        if ((c_size == 2'b01) && c_addr[0])               c_err = 1'b1;
        if ((c_size == 2'b10) && (c_addr[1:0] != 2'b00))  c_err = 1'b1;
    end

    assign a0  = c_addr[ADDR_W-1:0];
    assign a1  = a0 + ADDR_W'(1);
    assign a2  = a0 + ADDR_W'(2);
    assign a3  = a0 + ADDR_W'(3);
    assign b0  = mem[a0];
    assign b1  = mem[a1];
    assign b2  = mem[a2];
    assign b3  = mem[a3];
    assign ext = SIGN_EXT && c_sgn;

    always_comb begin
        rd_val = '0;
        case (c_size)
            2'b00:   rd_val = {{24{ext & b0[7]}}, b0};
            2'b01:   rd_val = {{16{ext & b0[7]}}, b0, b1};
            2'b10:   rd_val = {b0, b1, b2, b3};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        sgn_q   <= bus.req_signed;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'(LATENCY)) begin
                        state <= S_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (go_resp) begin
            rdata_q <= (c_err || c_we) ? '0 : rd_val;
            err_q   <= c_err;
        end
    end

    // Storage is never reset; the reset term drops a write whose edge coincides with reset.
    always_ff @(posedge clk) begin
        if (reset && go_resp && c_we && !c_err) begin
            case (c_size)
                2'b00: mem[a0] <= c_wdata[7:0];
                2'b01: begin
                    mem[a0] <= c_wdata[15:8];
                    mem[a1] <= c_wdata[7:0];
                end
                2'b10: begin
                    mem[a0] <= c_wdata[31:24];
                    mem[a1] <= c_wdata[23:16];
                    mem[a2] <= c_wdata[15:8];
                    mem[a3] <= c_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 and LATENCY=0 instances).
module tb_mem_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_responder_if b0 ();
    mem_responder_if b1 ();

    mem_responder #(.ADDR_W(8), .LATENCY(2)) u0 (.clk(clk), .reset(reset), .bus(b0));
    mem_responder #(.ADDR_W(8), .LATENCY(0)) u1 (.clk(clk), .reset(reset), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SIGN_EXT_EN
    localparam logic [31:0] EXP_HALF_S = 32'hFFFF_BEEF;
    localparam logic [31:0] EXP_BYTE_S = 32'hFFFF_FFEF;
`else
    localparam logic [31:0] EXP_HALF_S = 32'h0000_BEEF;
    localparam logic [31:0] EXP_BYTE_S = 32'h0000_00EF;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            b0.req_valid = v; b0.req_we = we; b0.req_size = sz;
            b0.req_signed = sg; b0.req_addr = a; b0.req_wdata = w;
        end else begin
            b1.req_valid = v; b1.req_we = we; b1.req_size = sz;
            b1.req_signed = sg; b1.req_addr = a; b1.req_wdata = w;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? b0.req_ready : b1.req_ready;
    endfunction
    function automatic logic rv(input int d);
        return (d == 0) ? b0.rsp_valid : b1.rsp_valid;
    endfunction
    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? b0.rsp_rdata : b1.rsp_rdata;
    endfunction
    function automatic logic rerr(input int d);
        return (d == 0) ? b0.rsp_err : b1.rsp_err;
    endfunction

    // One transaction; inputs are scrambled right after acceptance to show they are ignored.
    task automatic xact(input string tag, input int d, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int n;
        int lat;
        @(negedge clk);
        drive(d, 1'b1, we, sz, sg, a, w);
        n = 0;
        while (!rdy(d) && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(rdy(d)), 32'd1);
        @(posedge clk);
        #1 drive(d, 1'b0, ~we, ~sz, ~sg, ~a, ~w);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv(d) && lat < 16);
        chk({tag, ".lat"},   32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, rdat(d), exp_rd);
        chk({tag, ".err"},   32'(rerr(d)), 32'(exp_err));
        chk({tag, ".busy"},  32'(rdy(d)), 32'd0);
        @(negedge clk);
        chk({tag, ".strobe"}, 32'(rv(d)), 32'd0);
    endtask

    initial begin
        int          n_acc;
        int          n_rsp;
        int          acc_idx [2];
        logic [31:0] b2b_rd;
        logic        b2b_err;
        logic        seen;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(b0.req_ready), 32'd0);
        chk("rst.valid", 32'(b0.rsp_valid), 32'd0);
        chk("rst.rdata", b0.rsp_rdata, 32'd0);
        chk("rst.err",   32'(b0.rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.ready_after", 32'(b0.req_ready), 32'd1);

        // Word write / read and sub-word reads
        xact("w_wr10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        xact("w_rd10", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        xact("b_rd11", 0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_00AD, 1'b0, 3);
        xact("h_rd12", 0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0, 3);
        xact("h_rd12s", 0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, EXP_HALF_S, 1'b0, 3);
        xact("b_rd13s", 0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, EXP_BYTE_S, 1'b0, 3);

        // Sub-word writes
        xact("b_wr13", 0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5677, 32'h0, 1'b0, 3);
        xact("w_rd10b", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BE77, 1'b0, 3);
        xact("h_wr10", 0, 1'b1, 2'b01, 1'b0, 32'h10, 32'hAAAA_1234, 32'h0, 1'b0, 3);
        xact("w_rd10c", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_BE77, 1'b0, 3);

        // Error cases, then confirm memory untouched
        xact("e_wmis", 0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 3);
        xact("e_hwr21", 0, 1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF, 32'h0, 1'b1, 3);
        xact("e_hwr11", 0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 32'h0, 1'b1, 3);
        xact("e_sz11", 0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 3);
        xact("e_oor", 0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 3);
        xact("e_wwoor", 0, 1'b1, 2'b10, 1'b0, 32'h110, 32'h9999_9999, 32'h0, 1'b1, 3);
        xact("w_rd10d", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_BE77, 1'b0, 3);

        // Last address: byte ok, half misaligned
        xact("b_wrff", 0, 1'b1, 2'b00, 1'b0, 32'hFF, 32'h0000_00A5, 32'h0, 1'b0, 3);
        xact("b_rdff", 0, 1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, 32'h0000_00A5, 1'b0, 3);
        xact("e_hff", 0, 1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, 32'h0, 1'b1, 3);

        // Back-to-back with req_valid held; address disturbed during WAIT
        n_acc = 0;
        n_rsp = 0;
        acc_idx[0] = -1;
        acc_idx[1] = -1;
        b2b_rd  = '0;
        b2b_err = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (b0.req_ready && b0.req_valid) begin
                if (n_acc < 2) acc_idx[n_acc] = i;
                n_acc++;
            end
            if (b0.rsp_valid) begin
                n_rsp++;
                if (i == 3) begin
                    b2b_rd  = b0.rsp_rdata;
                    b2b_err = b0.rsp_err;
                end
            end
            if (i == 1) b0.req_addr = 32'h11;
            if (i == 3) b0.req_addr = 32'h10;
            if (i < 7) @(negedge clk);
        end
        b0.req_valid = 1'b0;
        chk("b2b.n_acc", 32'(n_acc), 32'd2);
        chk("b2b.acc0",  32'(acc_idx[0]), 32'd0);
        chk("b2b.acc1",  32'(acc_idx[1]), 32'd4);
        chk("b2b.n_rsp", 32'(n_rsp), 32'd2);
        chk("b2b.rdata", b2b_rd, 32'h1234_BE77);
        chk("b2b.err",   32'(b2b_err), 32'd0);
        @(negedge clk);

        // Reset during WAIT aborts a pending write
        xact("w_wr40z", 0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 3);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1111_1111);
        @(posedge clk);
        #1 b0.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid.valid", 32'(b0.rsp_valid), 32'd0);
        chk("mid.ready", 32'(b0.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("mid.ready_after", 32'(b0.req_ready), 32'd1);
            seen = seen | b0.rsp_valid;
        end
        chk("mid.no_rsp", 32'(seen), 32'd0);
        xact("w_rd40", 0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 3);

        // Zero-latency instance
        xact("l0_wr", 1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
        xact("l0_rd", 1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
        xact("l0_hrd", 1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_F00D, 1'b0, 1);
        xact("l0_err", 1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
